wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order writeback stage and a long-latency result source (mul/div unit, late load return).
- Pipeline writes have priority. Long-latency results are buffered in a DEPTH-entry FIFO and drain on idle port cycles.
- Provides WAW suppression, a pending-register hazard query, and a starvation stall request to the pipeline.
- Sits between the writeback mux output and the register file.

---
 rtl/wb_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results queue in a small FIFO with WAW kill, hazard query and starvation stall.
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pipe_we_i,
  input  logic [AW-1:0]            pipe_addr_i,
  input  logic [DW-1:0]            pipe_data_i,
  input  logic                     lu_valid_i,
  input  logic [AW-1:0]            lu_addr_i,
  input  logic [DW-1:0]            lu_data_i,
  output logic                     lu_ready_o,
  input  logic [AW-1:0]            query_addr_i,
  output logic                     query_hit_o,
  output logic                     stall_req_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     rf_we_o,
  output logic [AW-1:0]            rf_addr_o,
  output logic [DW-1:0]            rf_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]    q_addr [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  logic empty, full, lu_acc, head_live;
  logic deq, pipe_gnt, bypass, enq, kill, enq_live, hit;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign lu_ready_o  = !full;
  assign lu_acc      = lu_valid_i && !full;
  assign head_live   = !empty && q_live[rd_ptr];
  assign stall_req_o = (starve_cnt == SW'(STARVE_MAX));
  assign count_o     = count;

  // A stalled head always dequeues; otherwise the head only gets idle pipe cycles.
  assign deq      = !empty && (stall_req_o || !pipe_we_i);
  assign pipe_gnt = !stall_req_o && pipe_we_i;
  assign bypass   = !stall_req_o && !pipe_we_i && empty && lu_acc;
  assign enq      = lu_acc && !bypass;
  assign kill     = pipe_gnt && (pipe_addr_i != '0);
  assign enq_live = (lu_addr_i != '0) && !(kill && (lu_addr_i == pipe_addr_i));

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (q_live[i] && (q_addr[i] == query_addr_i)) hit = 1'b1;
  end
  assign query_hit_o = hit && (query_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (enq) begin
      q_addr[wr_ptr] <= lu_addr_i;
      q_data[wr_ptr] <= lu_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_live     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      rf_we_o    <= 1'b0;
      rf_addr_o  <= '0;
      rf_data_o  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill && (q_addr[i] == pipe_addr_i)) q_live[i] <= 1'b0;
      // Live bits are cleared on dequeue so only occupied slots can ever hit.
      if (deq) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PW'(1);
      end
      if (enq) begin
        q_live[wr_ptr] <= enq_live;
        wr_ptr         <= wr_ptr + PW'(1);
      end

      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (deq || !head_live)
        starve_cnt <= '0;
      else if (!stall_req_o)
        starve_cnt <= starve_cnt + SW'(1);

      rf_we_o <= 1'b0;
      if (deq) begin
        rf_we_o   <= q_live[rd_ptr] && (q_addr[rd_ptr] != '0);
        rf_addr_o <= q_addr[rd_ptr];
        rf_data_o <= q_data[rd_ptr];
      end else if (pipe_gnt) begin
        rf_we_o   <= (pipe_addr_i != '0);
        rf_addr_o <= pipe_addr_i;
        rf_data_o <= pipe_data_i;
      end else if (bypass) begin
        rf_we_o   <= (lu_addr_i != '0);
        rf_addr_o <= lu_addr_i;
        rf_data_o <= lu_data_i;
      end
    end
  end

endmodule
